// File: rtl/wb_stream_cfg_if.sv
// wb_stream_cfg_if: Wishbone slave bus bundle for the stream writer config block
interface wb_stream_cfg_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_stream_cfg.sv
// wb_stream_cfg: Wishbone register bank and buffer sequencer for the stream-to-memory writer
module wb_stream_cfg #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_stream_cfg_if.slave    bus,
  input  logic              mon_cyc_i,
  input  logic              mon_ack_i,
  input  logic              mon_err_i,
  output logic              enable,
  output logic [WB_AW-1:0]  start_adr,
  output logic [WB_AW-1:0]  buf_size,
  output logic [WB_AW-1:0]  burst_size,
  output logic              continous,
  output logic              irq
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic             irq_en, done, err, cfg_err, ack;
  logic [WB_AW-1:0] word_cnt;
  logic [31:0]      buf_cnt, rdata, dat_o;
  logic             acc, wr, cfg_wr, ctrl_wr, stat_wr, go, mack, merr, last, cfg_ok;
  logic             start_ok, start_bad, buf_end, set_err;
  logic [2:0]       rsel;
  logic             unused_adr;
  if (WB_DW != 32) begin : g_dw_check
    $error("wb_stream_cfg requires WB_DW == 32");
  end
  assign acc       = bus.wb_cyc_i & bus.wb_stb_i & ~ack;
  assign wr        = acc & bus.wb_we_i & (&bus.wb_sel_i);
  assign rsel      = bus.wb_adr_i[4:2];
  assign unused_adr = ^bus.wb_adr_i[1:0];
  assign cfg_wr    = wr & (state == IDLE);
  assign ctrl_wr   = wr & (rsel == 3'd0);
  assign stat_wr   = wr & (rsel == 3'd1);
  assign go        = bus.wb_dat_i[0];
  assign mack      = mon_cyc_i & mon_ack_i;
  assign merr      = mon_cyc_i & mon_err_i;
  assign last      = word_cnt == buf_size - WB_AW'(1);
  assign cfg_ok    = (buf_size != '0) & (burst_size != '0) & (burst_size <= buf_size);
  assign start_ok  = (state == IDLE) & ctrl_wr & go & cfg_ok;
  assign start_bad = (state == IDLE) & ctrl_wr & go & ~cfg_ok;
  assign buf_end   = (state == RUN) & mack & last;
  assign set_err   = (state == RUN) & merr;
  assign enable    = state == RUN;
  assign bus.wb_ack_o = ack;
  assign bus.wb_dat_o = dat_o;
  assign bus.wb_err_o = 1'b0;
  assign bus.wb_rty_o = 1'b0;
  // Next state: errors and stop requests force a drain so the writer can finish its bus cycle
  always_comb begin
    state_nxt = state == IDLE ? (start_ok ? RUN : IDLE) :
                state == RUN  ? ((merr | (ctrl_wr & ~go) | (buf_end & ~continous)) ? DRAIN : RUN) :
                (mon_cyc_i ? DRAIN : IDLE);
  end
  // Register readback mux, sampled into dat_o together with the ack
  always_comb begin
    rdata = '0;
    case (rsel)
      3'd0:    rdata = {29'd0, irq_en, continous, enable};
      3'd1:    rdata = {28'd0, cfg_err, err, done, state != IDLE};
      3'd2:    rdata = 32'(start_adr);
      3'd3:    rdata = 32'(buf_size);
      3'd4:    rdata = 32'(burst_size);
      3'd5:    rdata = 32'(word_cnt);
      3'd6:    rdata = buf_cnt;
      default: rdata = '0;
    endcase
  end
  // Sequencer state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  // Single-cycle ack, never back-to-back, read data captured with it
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack   <= 1'b0;
      dat_o <= '0;
    end else begin
      ack <= acc;
      if (acc) dat_o <= rdata;
    end
  end
  // Configuration registers; transfer geometry is frozen while a transfer is active
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en     <= 1'b0;
      continous  <= 1'b0;
      start_adr  <= '0;
      buf_size   <= '0;
      burst_size <= '0;
    end else begin
      if (ctrl_wr) irq_en <= bus.wb_dat_i[2];
      if (cfg_wr && rsel == 3'd0) continous <= bus.wb_dat_i[1];
      if (cfg_wr && rsel == 3'd2) start_adr <= WB_AW'(bus.wb_dat_i);
      if (cfg_wr && rsel == 3'd3) buf_size <= WB_AW'(bus.wb_dat_i);
      if (cfg_wr && rsel == 3'd4) burst_size <= WB_AW'(bus.wb_dat_i);
    end
  end
  // Sticky status flags with write-1-to-clear; a new event wins over a clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      done    <= 1'b0;
      err     <= 1'b0;
      cfg_err <= 1'b0;
      irq     <= 1'b0;
    end else begin
      done    <= buf_end | (done & ~(stat_wr & bus.wb_dat_i[1]));
      err     <= set_err | (err & ~(stat_wr & bus.wb_dat_i[2]));
      cfg_err <= start_bad | (cfg_err & ~(stat_wr & bus.wb_dat_i[3]));
      irq     <= irq_en & (done | err | cfg_err);
    end
  end
  // Word and buffer counters; an erroring buffer-end ack is counted without wrapping
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      word_cnt <= '0;
      buf_cnt  <= '0;
    end else begin
      if (start_ok) word_cnt <= '0;
      else if (state != IDLE && mack) word_cnt <= (buf_end && !merr) ? '0 : word_cnt + WB_AW'(1);
      if (buf_end) buf_cnt <= buf_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_wb_stream_cfg.sv
// tb_wb_stream_cfg: directed and randomized check of wb_stream_cfg against a behavioural model
module tb_wb_stream_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mon_cyc, mon_ack, mon_err, enable, continous, irq;
  logic [31:0] start_adr, buf_size, burst_size;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  wb_stream_cfg_if bus();
  wb_stream_cfg dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus),
    .mon_cyc_i(mon_cyc), .mon_ack_i(mon_ack), .mon_err_i(mon_err),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
    .burst_size(burst_size), .continous(continous), .irq(irq)
  );
  logic        m_ack, m_irq, m_irq_en, m_cont, m_run, m_drain, m_done, m_err, m_cfg;
  logic [31:0] m_dat, m_start, m_buf, m_burst, m_wc, m_bc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    {m_ack, m_irq, m_irq_en, m_cont, m_run, m_drain, m_done, m_err, m_cfg} = '0;
    {m_dat, m_start, m_buf, m_burst, m_wc, m_bc} = '0;
  endtask
  function automatic logic [31:0] mread(input logic [2:0] r);
    case (r)
      3'd0: return {29'd0, m_irq_en, m_cont, m_run};
      3'd1: return {28'd0, m_cfg, m_err, m_done, m_run | m_drain};
      3'd2: return m_start;
      3'd3: return m_buf;
      3'd4: return m_burst;
      3'd5: return m_wc;
      3'd6: return m_bc;
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_tick();
    logic acc, wr, idle, cnt, merr, stop;
    logic [2:0] r;
    logic [31:0] d;
    acc  = bus.wb_cyc_i & bus.wb_stb_i & !m_ack;
    wr   = acc & bus.wb_we_i & (bus.wb_sel_i == 4'hf);
    r    = bus.wb_adr_i[4:2];
    d    = bus.wb_dat_i;
    cnt  = mon_cyc & mon_ack;
    merr = mon_cyc & mon_err;
    idle = !m_run && !m_drain;
    m_irq = m_irq_en & (m_done | m_err | m_cfg);
    if (acc) m_dat = mread(r);
    m_ack = acc;
    if (wr && r == 3'd0) m_irq_en = d[2];
    if (wr && r == 3'd1) begin
      if (d[1]) m_done = 1'b0;
      if (d[2]) m_err = 1'b0;
      if (d[3]) m_cfg = 1'b0;
    end
    if (wr && idle) begin
      if (r == 3'd0) m_cont = d[1];
      if (r == 3'd2) m_start = d;
      if (r == 3'd3) m_buf = d;
      if (r == 3'd4) m_burst = d;
    end
    if (idle) begin
      if (wr && r == 3'd0 && d[0]) begin
        if (m_buf != 0 && m_burst != 0 && m_burst <= m_buf) begin
          m_run = 1'b1;
          m_wc = 0;
        end else m_cfg = 1'b1;
      end
    end else if (m_run) begin
      stop = merr || (wr && r == 3'd0 && !d[0]);
      if (cnt) begin
        if (m_wc == m_buf - 1) begin
          m_done = 1'b1;
          m_bc = m_bc + 1;
          m_wc = merr ? m_wc + 1 : 0;
          stop = stop | !m_cont;
        end else m_wc = m_wc + 1;
      end
      if (merr) m_err = 1'b1;
      if (stop) begin
        m_run = 1'b0;
        m_drain = 1'b1;
      end
    end else begin
      if (cnt) m_wc = m_wc + 1;
      if (!mon_cyc) m_drain = 1'b0;
    end
  endtask
  task automatic step(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic mc, input logic ma, input logic me);
    bus.wb_cyc_i = c;
    bus.wb_stb_i = c;
    bus.wb_we_i  = w;
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_sel_i = s;
    mon_cyc = mc;
    mon_ack = ma;
    mon_err = me;
    @(posedge clk);
    model_tick();
    #1;
    chk("ack", bus.wb_ack_o, m_ack);
    chk("dat", bus.wb_dat_o, m_dat);
    chk("enable", enable, m_run);
    chk("irq", irq, m_irq);
    chk("start_adr", start_adr, m_start);
    chk("buf_size", buf_size, m_buf);
    chk("burst_size", burst_size, m_burst);
    chk("continous", continous, m_cont);
    chk("err_rty", {bus.wb_err_o, bus.wb_rty_o}, 0);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1, 1, a, d, 4'hf, 0, 0, 0);
    step(0, 0, 0, 0, 4'hf, 0, 0, 0);
  endtask
  task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    step(1, 0, a, 0, 4'hf, 0, 0, 0);
    v = bus.wb_dat_o;
    step(0, 0, 0, 0, 4'hf, 0, 0, 0);
    chk(tag, v, exp);
  endtask
  task automatic mon(input logic mc, input logic ma, input logic me);
    step(0, 0, 0, 0, 4'hf, mc, ma, me);
  endtask
  logic        r_c, r_w, r_mc, r_ma, r_me;
  logic [4:0]  r_a;
  logic [31:0] r_d;
  logic [3:0]  r_s;
  initial begin
    {bus.wb_cyc_i, bus.wb_stb_i, bus.wb_we_i} = '0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = 4'hf;
    {mon_cyc, mon_ack, mon_err} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", enable, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ack", bus.wb_ack_o, 0);
    chk("rst_dat", bus.wb_dat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rdchk("rst_reg", 5'(i * 4), 0);
    wr(5'h08, 32'h1000);
    wr(5'h0C, 8);
    wr(5'h10, 4);
    wr(5'h00, 1);
    chk("en_run", enable, 1);
    chk("start_adr_out", start_adr, 32'h1000);
    for (int i = 0; i < 8; i++) begin
      rdchk("wc_run", 5'h14, 32'(i));
      mon(1, 1, 0);
    end
    chk("en_done", enable, 0);
    rdchk("st_drain", 5'h04, 3);
    rdchk("st_idle", 5'h04, 2);
    rdchk("bc_one", 5'h18, 1);
    rdchk("wc_wrap", 5'h14, 0);
    wr(5'h04, 2);
    wr(5'h0C, 4);
    wr(5'h00, 3);
    for (int b = 0; b < 3; b++) begin
      repeat (4) mon(1, 1, 0);
      rdchk("st_cont", 5'h04, 3);
      wr(5'h04, 2);
    end
    chk("en_cont", enable, 1);
    rdchk("bc_cont", 5'h18, 4);
    rdchk("wc_cont", 5'h14, 0);
    wr(5'h00, 0);
    chk("en_cont_stop", enable, 0);
    rdchk("st_cont_stop", 5'h04, 0);
    wr(5'h0C, 4);
    wr(5'h10, 5);
    wr(5'h00, 1);
    chk("en_cfg", enable, 0);
    rdchk("cfg_burst", 5'h04, 8);
    wr(5'h04, 8);
    rdchk("cfg_clear", 5'h04, 0);
    wr(5'h0C, 0);
    wr(5'h10, 1);
    wr(5'h00, 1);
    rdchk("cfg_zero", 5'h04, 8);
    wr(5'h04, 8);
    wr(5'h0C, 8);
    wr(5'h10, 2);
    wr(5'h00, 1);
    repeat (3) mon(1, 1, 0);
    wr(5'h0C, 99);
    rdchk("buf_lock", 5'h0C, 8);
    wr(5'h00, 0);
    chk("en_stop", enable, 0);
    rdchk("wc_stop", 5'h14, 3);
    rdchk("st_stop", 5'h04, 0);
    wr(5'h00, 5);
    repeat (7) mon(1, 1, 0);
    mon(1, 1, 1);
    chk("en_err", enable, 0);
    chk("irq_latency", irq, 0);
    mon(0, 0, 0);
    chk("irq_set", irq, 1);
    rdchk("st_err", 5'h04, 6);
    rdchk("wc_nowrap", 5'h14, 8);
    rdchk("bc_err", 5'h18, 5);
    wr(5'h04, 32'hE);
    chk("irq_clear", irq, 0);
    wr(5'h00, 1);
    repeat (2) mon(1, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("en_async", enable, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) rdchk("rst_run_reg", 5'(i * 4), 0);
    for (int i = 0; i < 3000; i++) begin
      r_c  = !m_ack && ($urandom % 3 == 0);
      r_w  = $urandom % 2 == 0;
      r_a  = 5'($urandom_range(0, 31));
      case (r_a[4:2])
        3'd0:    r_d = $urandom % 8;
        3'd1:    r_d = $urandom % 16;
        3'd3:    r_d = $urandom_range(0, 6);
        3'd4:    r_d = $urandom_range(0, 6);
        default: r_d = $urandom;
      endcase
      r_s  = ($urandom % 8 == 0) ? 4'($urandom) : 4'hf;
      r_mc = $urandom % 4 != 0;
      r_ma = $urandom % 2 == 0;
      r_me = $urandom % 64 == 0;
      step(r_c, r_w, r_a, r_d, r_s, r_mc, r_ma, r_me);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
